// File: rtl/ram_two_port_arbiter.sv
// Zero-fills a single-port synchronous RAM after reset, then shares its
// one port between requesters A and B with round-robin arbitration.
module ram_two_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_d,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_q,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_d,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_q,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_d,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic                  init_done
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST =
      (ADDR_WIDTH+1)'(DEPTH - 1);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH:0]   r_cnt;
   logic [ADDR_WIDTH:0]   w_cnt_nxt;
   logic                  r_ptr;
   logic                  w_ptr_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_d;
   logic                  r_a_rvalid;
   logic                  r_b_rvalid;
   logic                  w_a_gnt;
   logic                  w_b_gnt;

   // r_ptr = 0 gives A the win on a tie, 1 gives B
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      w_a_gnt     = 1'b0;
      w_b_gnt     = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = r_addr;
      ram_d       = r_d;
      unique case (r_state)
         S_INIT: begin
            ram_we    = 1'b1;
            ram_addr  = r_cnt[ADDR_WIDTH-1:0];
            ram_d     = '0;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == LAST)
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_a_gnt = a_req & (~b_req | ~r_ptr);
            w_b_gnt = b_req & (~a_req | r_ptr);
            if (w_a_gnt) begin
               ram_we    = a_we;
               ram_addr  = a_addr;
               ram_d     = a_d;
               w_ptr_nxt = 1'b1;
            end else if (w_b_gnt) begin
               ram_we    = b_we;
               ram_addr  = b_addr;
               ram_d     = b_d;
               w_ptr_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_INIT;
         r_cnt      <= '0;
         r_ptr      <= 1'b0;
         r_addr     <= '0;
         r_d        <= '0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
         r_addr     <= ram_addr;
         r_d        <= ram_d;
         r_a_rvalid <= w_a_gnt & ~a_we;
         r_b_rvalid <= w_b_gnt & ~b_we;
      end
   end

   assign a_gnt     = w_a_gnt;
   assign b_gnt     = w_b_gnt;
   assign a_rvalid  = r_a_rvalid;
   assign b_rvalid  = r_b_rvalid;
   assign a_q       = ram_q;
   assign b_q       = ram_q;
   assign init_done = (r_state == S_RUN);

endmodule

// File: tb/tb_ram_two_port_arbiter.sv
// Bench for ram_two_port_arbiter: directed vector table, corner sequences
// and random traffic against a behavioural memory/arbitration model.
module tb_ram_two_port_arbiter;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_d, b_d;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_q, b_q;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] ram_q;
   logic          init_done;

   ram_two_port_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we),
      .a_addr(a_addr), .a_d(a_d),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid),
      .a_q(a_q),
      .b_req(b_req), .b_we(b_we),
      .b_addr(b_addr), .b_d(b_d),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid),
      .b_q(b_q),
      .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_d(ram_d), .ram_q(ram_q),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   // single-port RAM, registered read, read-before-write
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_d;
      ram_q <= mem[ram_addr];
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string n, input int act,
                      input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  n, act, exp);
      end
   endtask

   // behavioural model state
   int            m_left;
   bit            m_last_b;
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_pa, m_pb;
   int            m_pq;

   // values seen at the last sample point
   int s_ag, s_bg, s_arv, s_brv, s_aq, s_bq, s_id;

   task automatic model_reset();
      m_left   = DEPTH;
      m_last_b = 1'b1;
      m_pa     = 1'b0;
      m_pb     = 1'b0;
   endtask

   task automatic cycle();
      bit run, ea, eb, we;
      int ad, dd;
      run = (m_left == 0);
      ea  = 1'b0;
      eb  = 1'b0;
      if (run) begin
         if (a_req && b_req) begin
            ea = m_last_b;
            eb = !m_last_b;
         end else begin
            ea = a_req;
            eb = b_req;
         end
      end
      we = ea ? a_we : (eb ? b_we : 1'b0);
      ad = ea ? int'(a_addr) : int'(b_addr);
      dd = ea ? int'(a_d) : int'(b_d);
      @(negedge clk);
      s_ag  = int'(a_gnt);
      s_bg  = int'(b_gnt);
      s_arv = int'(a_rvalid);
      s_brv = int'(b_rvalid);
      s_aq  = int'(a_q);
      s_bq  = int'(b_q);
      s_id  = int'(init_done);
      chk("a_gnt", s_ag, int'(ea));
      chk("b_gnt", s_bg, int'(eb));
      chk("init_done", s_id, int'(run));
      chk("a_rvalid", s_arv, int'(m_pa));
      chk("b_rvalid", s_brv, int'(m_pb));
      if (m_pa) chk("a_q", s_aq, m_pq);
      if (m_pb) chk("b_q", s_bq, m_pq);
      if (!run) begin
         chk("clr_we", int'(ram_we), 1);
         chk("clr_addr", int'(ram_addr), DEPTH - m_left);
         chk("clr_d", int'(ram_d), 0);
      end else if (ea || eb) begin
         chk("ram_we", int'(ram_we), int'(we));
         chk("ram_addr", int'(ram_addr), ad);
         if (we) chk("ram_d", int'(ram_d), dd);
      end else begin
         chk("idle_we", int'(ram_we), 0);
      end
      @(posedge clk);
      m_pa = ea && !we;
      m_pb = eb && !we;
      if (m_pa || m_pb) m_pq = int'(m_mem[ad]);
      if ((ea || eb) && we) m_mem[ad] = DW'(dd);
      if (ea) m_last_b = 1'b0;
      if (eb) m_last_b = 1'b1;
      if (!run) begin
         m_left--;
         if (m_left == 0)
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
      if (reset) model_reset();
      #1;
   endtask

   typedef struct {
      int a_req, a_we, a_addr, a_d;
      int b_req, b_we, b_addr, b_d;
      int e_ag, e_bg, e_arv, e_brv, e_q;
   } vec_t;

   vec_t tbl [18];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0]  = '{1,1,7,'hA5, 0,0,0,0, 1,0,0,0,0};
      tbl[1]  = '{1,0,7,0,    0,0,0,0, 1,0,0,0,0};
      tbl[2]  = '{0,0,0,0,    0,0,0,0, 0,0,1,0,'hA5};
      tbl[3]  = '{1,1,1,'h11, 0,0,0,0, 1,0,0,0,0};
      tbl[4]  = '{0,0,0,0, 1,1,2,'h22, 0,1,0,0,0};
      tbl[5]  = '{1,0,1,0,    1,0,2,0, 1,0,0,0,0};
      tbl[6]  = '{1,0,1,0,    1,0,2,0, 0,1,1,0,'h11};
      tbl[7]  = '{1,0,1,0,    1,0,2,0, 1,0,0,1,'h22};
      tbl[8]  = '{1,0,1,0,    1,0,2,0, 0,1,1,0,'h11};
      tbl[9]  = '{0,0,0,0,    0,0,0,0, 0,0,0,1,'h22};
      tbl[10] = '{1,1,0,'h50, 0,0,0,0, 1,0,0,0,0};
      tbl[11] = '{1,1,3,'h33, 0,0,0,0, 1,0,0,0,0};
      tbl[12] = '{1,0,0,0,    0,0,0,0, 1,0,0,0,0};
      tbl[13] = '{1,0,1,0,    0,0,0,0, 1,0,1,0,'h50};
      tbl[14] = '{1,0,2,0,    0,0,0,0, 1,0,1,0,'h11};
      tbl[15] = '{1,0,3,0,    0,0,0,0, 1,0,1,0,'h22};
      tbl[16] = '{0,0,0,0,    0,0,0,0, 0,0,1,0,'h33};
      tbl[17] = '{0,0,0,0,    0,0,0,0, 0,0,0,0,0};

      reset  = 1'b1;
      a_req  = 1'b0; a_we = 1'b0;
      a_addr = '0;   a_d  = '0;
      b_req  = 1'b0; b_we = 1'b0;
      b_addr = '0;   b_d  = '0;
      @(posedge clk);
      #1;
      model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      cycle();
      chk("rst_init_done", s_id, 0);
      chk("rst_a_rvalid", s_arv, 0);
      chk("rst_b_rvalid", s_brv, 0);

      // A requests throughout the clear
      reset = 1'b0;
      a_req = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         cycle();
         chk("init_a_gnt", s_ag, 0);
      end
      cycle();
      chk("first_run_a_gnt", s_ag, 1);
      chk("first_run_done", s_id, 1);

      // every word reads back as zero
      for (int i = 0; i < DEPTH; i++) begin
         a_addr = AW'(i);
         cycle();
         if (s_arv != 0) chk("zero_rd", s_aq, 0);
      end
      a_req = 1'b0;
      cycle();
      chk("zero_rd_last", s_aq, 0);

      foreach (tbl[i]) begin
         a_req  = tbl[i].a_req[0];
         a_we   = tbl[i].a_we[0];
         a_addr = AW'(tbl[i].a_addr);
         a_d    = DW'(tbl[i].a_d);
         b_req  = tbl[i].b_req[0];
         b_we   = tbl[i].b_we[0];
         b_addr = AW'(tbl[i].b_addr);
         b_d    = DW'(tbl[i].b_d);
         cycle();
         chk($sformatf("r%0d_a_gnt", i), s_ag, tbl[i].e_ag);
         chk($sformatf("r%0d_b_gnt", i), s_bg, tbl[i].e_bg);
         chk($sformatf("r%0d_a_rv", i), s_arv, tbl[i].e_arv);
         chk($sformatf("r%0d_b_rv", i), s_brv, tbl[i].e_brv);
         if (tbl[i].e_arv != 0)
            chk($sformatf("r%0d_a_q", i), s_aq, tbl[i].e_q);
         if (tbl[i].e_brv != 0)
            chk($sformatf("r%0d_b_q", i), s_bq, tbl[i].e_q);
      end

      // reset the cycle after a read grant
      a_req  = 1'b1;
      a_we   = 1'b0;
      a_addr = 4'd7;
      cycle();
      chk("pre_rst_gnt", s_ag, 1);
      a_req = 1'b0;
      reset = 1'b1;
      cycle();
      chk("pre_rst_rvalid", s_arv, 1);
      reset = 1'b0;
      cycle();
      chk("post_rst_rvalid", s_arv, 0);

      // reset again when the clear counter reaches 9
      for (int i = 1; i < 9; i++) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      n = 0;
      s_id = 0;
      while (s_id == 0 && n < 40) begin
         cycle();
         if (s_id == 0) n++;
      end
      chk("reinit_len", n, DEPTH);

      // random traffic, each requester holds until granted
      a_req = 1'b0;
      b_req = 1'b0;
      s_ag  = 0;
      s_bg  = 0;
      for (int c = 0; c < 400; c++) begin
         if (!a_req || s_ag != 0) begin
            a_req  = ($urandom_range(0, 3) != 0);
            a_we   = 1'($urandom);
            a_addr = AW'($urandom);
            a_d    = DW'($urandom);
         end
         if (!b_req || s_bg != 0) begin
            b_req  = ($urandom_range(0, 3) != 0);
            b_we   = 1'($urandom);
            b_addr = AW'($urandom);
            b_d    = DW'($urandom);
         end
         cycle();
         if (s_ag != 0 && s_bg != 0)
            chk("both_gnt", 1, 0);
         if (s_arv != 0 && s_brv != 0)
            chk("both_rvalid", 1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
